// File: rtl/mac_feeder_if.sv
// Bundles the operand stream, mac_core drive/readback and result handshake of mac_feeder.
// slave = the feeder's view, master = the surrounding environment.
interface mac_feeder_if #(
  parameter int OP_W = 8
);
  logic            in_valid;
  logic            in_ready;
  logic [OP_W-1:0] in_act;
  logic [OP_W-1:0] in_wgt;
  logic            in_last;

  logic            mac_chip_sel;
  logic            mac_wr_en;
  logic            mac_rd_en;
  logic [15:0]     mac_data_in;
  logic [15:0]     mac_data_out;
  logic            mac_output_ready;

  logic            res_valid;
  logic            res_ready;
  logic [15:0]     res_data;
  logic            busy;

  modport slave (
    input  in_valid, in_act, in_wgt, in_last, mac_data_out, mac_output_ready, res_ready,
    output in_ready, mac_chip_sel, mac_wr_en, mac_rd_en, mac_data_in, res_valid, res_data, busy
  );

  modport master (
    output in_valid, in_act, in_wgt, in_last, mac_data_out, mac_output_ready, res_ready,
    input  in_ready, mac_chip_sel, mac_wr_en, mac_rd_en, mac_data_in, res_valid, res_data, busy
  );
endinterface

// File: rtl/mac_feeder.sv
// Streams operand products into mac_core and returns per-vector dot products (readout minus base).
// Define MAC_FEEDER_SIGNED_EN for two's-complement operands; default is unsigned.
module mac_feeder #(
  parameter int VEC_LEN = 8,
  parameter int OP_W    = 8   // 2*OP_W must be 16: mac_core is a 16-bit accumulator
) (
  input  logic         clk,
  input  logic         reset,
  mac_feeder_if.slave  bus
);
  localparam int CNT_W = $clog2(VEC_LEN + 1);

  typedef enum logic [2:0] {ACCEPT, FLUSH, READ, CAPTURE, RESULT} state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_pv;
  logic [15:0]        r_prod;
  logic [CNT_W-1:0]   r_beat_cnt;
  logic [15:0]        r_base;
  logic [15:0]        r_res_data;
  logic               r_res_valid;

  logic               w_beat;
  logic               w_last_beat;
  logic [15:0]        w_act_x;
  logic [15:0]        w_wgt_x;
  logic [15:0]        w_prod;

  // Widening to 16 bits before multiplying keeps exactly the low 16 product bits.
`ifdef MAC_FEEDER_SIGNED_EN
  assign w_act_x = {{(16-OP_W){bus.in_act[OP_W-1]}}, bus.in_act};
  assign w_wgt_x = {{(16-OP_W){bus.in_wgt[OP_W-1]}}, bus.in_wgt};
`else
  assign w_act_x = {{(16-OP_W){1'b0}}, bus.in_act};
  assign w_wgt_x = {{(16-OP_W){1'b0}}, bus.in_wgt};
`endif
  assign w_prod      = w_act_x * w_wgt_x;
  assign w_beat      = bus.in_valid && (r_state == ACCEPT);
  assign w_last_beat = w_beat && (bus.in_last || (r_beat_cnt == CNT_W'(VEC_LEN - 1)));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ACCEPT;
    else       r_state <= w_next;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ACCEPT:  if (w_last_beat)                       w_next = FLUSH;
      FLUSH:                                          w_next = READ;
      READ:                                           w_next = CAPTURE;
      CAPTURE: if (bus.mac_output_ready)              w_next = RESULT;
      RESULT:  if (bus.res_ready)                     w_next = ACCEPT;
      default:                                        w_next = ACCEPT;
    endcase
  end

  // NOTE: base must reset together with mac_core's accumulator, so all datapath registers reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pv        <= 1'b0;
      r_prod      <= '0;
      r_beat_cnt  <= '0;
      r_base      <= '0;
      r_res_data  <= '0;
      r_res_valid <= 1'b0;
    end else begin
      r_pv <= w_beat;
      if (w_beat) begin
        r_prod     <= w_prod;
        r_beat_cnt <= r_beat_cnt + CNT_W'(1);
      end
      if (r_state == CAPTURE && bus.mac_output_ready) begin
        r_res_data  <= bus.mac_data_out - r_base;
        r_base      <= bus.mac_data_out;
        r_res_valid <= 1'b1;
      end
      if (r_state == RESULT && bus.res_ready) begin
        r_res_valid <= 1'b0;
        r_beat_cnt  <= '0;
      end
    end
  end

  always_comb begin
    bus.in_ready     = (r_state == ACCEPT);
    bus.mac_rd_en    = (r_state == READ);
    bus.mac_wr_en    = r_pv;
    bus.mac_chip_sel = r_pv || (r_state == READ);
    bus.mac_data_in  = r_pv ? r_prod : 16'd0;
    bus.res_valid    = r_res_valid;
    bus.res_data     = r_res_data;
    bus.busy         = !((r_state == ACCEPT) && (r_beat_cnt == '0));
  end
endmodule

// File: tb/tb_mac_feeder.sv
// Self-checking bench for mac_feeder with a behavioural mac_core and a dot-product reference.
module tb_mac_feeder;
  localparam int VEC_LEN = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mac_feeder_if #(.OP_W(8)) bus();

  mac_feeder #(.VEC_LEN(VEC_LEN), .OP_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural mac_core: accumulates writes, answers a read one cycle later.
  logic [15:0] mc_acc;
  always @(posedge clk) begin
    if (reset) begin
      mc_acc               <= '0;
      bus.mac_output_ready <= 1'b0;
      bus.mac_data_out     <= '0;
    end else begin
      if (bus.mac_chip_sel && bus.mac_wr_en) mc_acc <= mc_acc + bus.mac_data_in;
      bus.mac_output_ready <= bus.mac_chip_sel && bus.mac_rd_en;
      if (bus.mac_chip_sel && bus.mac_rd_en) bus.mac_data_out <= mc_acc;
    end
  end

  // Monitor, sampled mid-cycle.
  logic [15:0] wr_q[$];
  int rd_cnt, rd_idx;
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.mac_chip_sel && bus.mac_wr_en) wr_q.push_back(bus.mac_data_in);
      if (bus.mac_rd_en) begin
        rd_cnt = rd_cnt + 1;
        rd_idx = cyc;
      end
    end
  end

  function automatic logic [15:0] prod_ref(input logic [7:0] a, input logic [7:0] w);
    int pa, pw;
`ifdef MAC_FEEDER_SIGNED_EN
    pa = $signed(a);
    pw = $signed(w);
`else
    pa = a;
    pw = w;
`endif
    return 16'(pa * pw);
  endfunction

  logic [7:0] v_act[VEC_LEN];
  logic [7:0] v_wgt[VEC_LEN];
  int         v_gap[VEC_LEN];
  int         v_n;
  bit         v_use_last;
  int         v_hold;

  function automatic logic [15:0] model_sum();
    logic [15:0] s = 16'd0;
    for (int i = 0; i < v_n; i++) s = s + prod_ref(v_act[i], v_wgt[i]);
    return s;
  endfunction

  task automatic fail_chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Caller is at posedge+#1 with the DUT idle in ACCEPT.
  task automatic run_vector(input string name, input logic [15:0] exp_res);
    int t_last;
    int waited;
    logic [15:0] exp_w[$];
    wr_q.delete();
    rd_cnt = 0;
    rd_idx = -1;
    t_last = -100;
    bus.res_ready = (v_hold == 0);
    for (int i = 0; i < v_n; i++) begin
      exp_w.push_back(prod_ref(v_act[i], v_wgt[i]));
      for (int g = 0; g < v_gap[i]; g++) begin
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
      end
      bus.in_valid = 1'b1;
      bus.in_act   = v_act[i];
      bus.in_wgt   = v_wgt[i];
      bus.in_last  = v_use_last && (i == v_n - 1);
      fail_chk({name, " in_ready"}, bus.in_ready, 1);
      if (i == v_n - 1) t_last = cyc;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    fail_chk({name, " in_ready after last"}, bus.in_ready, 0);
    fail_chk({name, " busy after last"}, bus.busy, 1);
    waited = 0;
    while (bus.res_valid !== 1'b1 && waited < 20) begin
      fail_chk({name, " no early res_valid with in_ready"}, bus.in_ready && bus.res_valid, 0);
      @(posedge clk); #1;
      waited++;
    end
    fail_chk({name, " res_valid seen"}, bus.res_valid, 1);
    fail_chk({name, " res latency"}, cyc - t_last, 4);
    fail_chk({name, " res_data"}, bus.res_data, exp_res);
    fail_chk({name, " rd pulses"}, rd_cnt, 1);
    fail_chk({name, " rd latency"}, rd_idx - t_last, 2);
    fail_chk({name, " write count"}, wr_q.size(), exp_w.size());
    if (wr_q.size() == exp_w.size())
      for (int i = 0; i < exp_w.size(); i++)
        fail_chk($sformatf("%s write %0d", name, i), wr_q[i], exp_w[i]);
    for (int h = 0; h < v_hold; h++) begin
      @(posedge clk); #1;
      fail_chk({name, " hold res_valid"}, bus.res_valid, 1);
      fail_chk({name, " hold res_data"}, bus.res_data, exp_res);
      fail_chk({name, " hold in_ready"}, bus.in_ready, 0);
    end
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    fail_chk({name, " res_valid cleared"}, bus.res_valid, 0);
    fail_chk({name, " in_ready restored"}, bus.in_ready, 1);
    fail_chk({name, " busy cleared"}, bus.busy, 0);
  endtask

  task automatic set_beat(input int i, input int a, input int w, input int gap);
    v_act[i] = 8'(a);
    v_wgt[i] = 8'(w);
    v_gap[i] = gap;
  endtask

  task automatic check_reset_outputs(input string name);
    fail_chk({name, " in_ready"}, bus.in_ready, 1);
    fail_chk({name, " busy"}, bus.busy, 0);
    fail_chk({name, " res_valid"}, bus.res_valid, 0);
    fail_chk({name, " res_data"}, bus.res_data, 0);
    fail_chk({name, " chip_sel"}, bus.mac_chip_sel, 0);
    fail_chk({name, " wr_en"}, bus.mac_wr_en, 0);
    fail_chk({name, " rd_en"}, bus.mac_rd_en, 0);
    fail_chk({name, " data_in"}, bus.mac_data_in, 0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_act = '0; bus.in_wgt = '0;
    bus.res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("post reset");
  endtask

  task automatic test_unsigned();
    v_n = 3; v_use_last = 1; v_hold = 0;
    set_beat(0, 3, 4, 0); set_beat(1, 5, 6, 0); set_beat(2, 2, 10, 0);
    run_vector("unsigned", 16'd62);
  endtask

  task automatic test_base();
    v_n = 2; v_use_last = 1; v_hold = 0;
    set_beat(0, 1, 1, 0); set_beat(1, 7, 7, 0);
    run_vector("base", 16'd50);
  endtask

  task automatic test_wrap();
    v_n = VEC_LEN; v_use_last = 0; v_hold = 0;
    for (int i = 0; i < VEC_LEN; i++) set_beat(i, 255, 255, 0);
`ifdef MAC_FEEDER_SIGNED_EN
    run_vector("wrap", 16'd8);
`else
    run_vector("wrap", 16'd61448);
`endif
  endtask

  task automatic test_backpressure();
    v_n = 2; v_use_last = 1; v_hold = 5;
    set_beat(0, 2, 2, 0); set_beat(1, 3, 3, 2);
    run_vector("backpressure", 16'd13);
  endtask

  task automatic test_signed();
    v_n = 2; v_use_last = 1; v_hold = 0;
    set_beat(0, -2, 3, 0); set_beat(1, 4, 5, 0);
`ifdef MAC_FEEDER_SIGNED_EN
    run_vector("signed", 16'd14);
`else
    run_vector("signed", 16'd782);
`endif
  endtask

  task automatic test_reset_mid();
    bus.in_valid = 1'b1; bus.in_act = 8'd9; bus.in_wgt = 8'd9; bus.in_last = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("reset mid");
    reset = 1'b0;
    v_n = 1; v_use_last = 1; v_hold = 0;
    set_beat(0, 1, 2, 0);
    run_vector("after reset", 16'd2);
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++) begin
      v_n = $urandom_range(VEC_LEN, 1);
      v_use_last = (v_n < VEC_LEN) ? 1'b1 : 1'($urandom_range(1, 0));
      v_hold = $urandom_range(3, 0);
      for (int i = 0; i < v_n; i++)
        set_beat(i, $urandom_range(255, 0), $urandom_range(255, 0),
                 ($urandom_range(3, 0) == 0) ? $urandom_range(2, 1) : 0);
      run_vector($sformatf("random %0d", k), model_sum());
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_base();
    test_wrap();
    test_backpressure();
    test_signed();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
